// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word fetch at a time to instruction
// memory, queues returned instructions in a 2-entry in-order buffer and
// presents the head entry to decode. A redirect flushes the buffer, restarts
// fetch at the new PC and squashes any response still in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic        redirect_pc_unused;

  // FSM state register; reset forgets any outstanding response
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // FSM next state; an in-flight request squashed by redirect drains via DROP
  always_comb begin
    state_next = state;
    case (state)
      S_REQ: begin
        if (accept) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   state_next = S_REQ;
        else if (redirect) state_next = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // FSM outputs and buffer handshakes; redirect suppresses request, push and pop
  always_comb begin
    imem_req  = !rst && (state == S_REQ) && (count < 2'd2) && !redirect;
    imem_addr = {fetch_pc[31:2], 2'b00};
    accept    = imem_req && imem_ready;
    push      = (state == S_WAIT) && imem_rvalid && !redirect;
    if_valid  = !rst && (count != 2'd0);
    pop       = if_valid && !stall && !redirect;
    wr_idx    = pop ? (count == 2'd2) : (count != 2'd0);
    if_instr  = if_valid ? buf_instr[0] : NOP;
    if_pc     = if_valid ? buf_pc[0] : 32'h0000_0000;
    if_opcode = if_instr[6:0];
    redirect_pc_unused = ^redirect_pc[1:0];
  end

  // Fetch PC, outstanding-request PC and the shifting 2-entry buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= 2'd0;
    end else begin
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        buf_pc[0]    <= buf_pc[1];
        buf_instr[0] <= buf_instr[1];
      end
      if (push) begin
        buf_pc[wr_idx]    <= req_pc;
        buf_instr[wr_idx] <= imem_rdata;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
